// File: rtl/fcmp_pipe.sv
// rtl/fcmp_pipe.sv - pipelined floating-point compare/classify unit
// Stage 1 classifies operands, shift stages carry them, final stage decides.
module fcmp_pipe #(
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 23,
  parameter int LATENCY = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [2:0]             i_mode,
  input  logic [EXP_W+MAN_W:0]   i_op_a,
  input  logic [EXP_W+MAN_W:0]   i_op_b,
  output logic                   o_result,
  output logic                   o_unordered,
  output logic                   o_ready,
  output logic                   o_busy
);

  localparam int M_W = EXP_W + MAN_W;

  localparam logic [2:0] MODE_ISPOS  = 3'b000;
  localparam logic [2:0] MODE_ISNEG  = 3'b001;
  localparam logic [2:0] MODE_ISZERO = 3'b010;
  localparam logic [2:0] MODE_EQ     = 3'b011;
  localparam logic [2:0] MODE_LT     = 3'b100;
  localparam logic [2:0] MODE_LE     = 3'b101;
  localparam logic [2:0] MODE_ISNAN  = 3'b110;

  typedef struct packed {
    logic [2:0]     mode;
    logic           a_sign;
    logic           a_zero;
    logic           a_nan;
    logic [M_W-1:0] a_mag;
    logic           b_sign;
    logic           b_zero;
    logic           b_nan;
    logic [M_W-1:0] b_mag;
  } stage_t;

  stage_t             w_cls;
  stage_t             w_fin;
  stage_t             r_d [LATENCY];
  logic [LATENCY-1:0] r_v;
  logic               r_result;
  logic               r_unordered;
  logic               r_ready;

  always_comb begin
    w_cls        = '0;
    w_cls.mode   = i_mode;
    w_cls.a_sign = i_op_a[M_W];
    w_cls.a_zero = ~|i_op_a[M_W-1:MAN_W];
    w_cls.a_nan  = (&i_op_a[M_W-1:MAN_W]) & (|i_op_a[MAN_W-1:0]);
    w_cls.a_mag  = i_op_a[M_W-1:0];
    w_cls.b_sign = i_op_b[M_W];
    w_cls.b_zero = ~|i_op_b[M_W-1:MAN_W];
    w_cls.b_nan  = (&i_op_b[M_W-1:MAN_W]) & (|i_op_b[MAN_W-1:0]);
    w_cls.b_mag  = i_op_b[M_W-1:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v <= '0;
      for (int k = 0; k < LATENCY; k++) r_d[k] <= '0;
    end else begin
      r_v[0] <= i_start;
      if (i_start) r_d[0] <= w_cls;
      for (int k = 1; k < LATENCY; k++) begin
        r_v[k] <= r_v[k-1];
        r_d[k] <= r_d[k-1];
      end
    end
  end

  assign w_fin = r_d[LATENCY-1];

  logic w_mag_lt;
  logic w_mag_eq;
  logic w_eq;
  logic w_lt;
  logic w_any_nan;
  logic w_res;
  logic w_unord;

  assign w_mag_lt  = w_fin.a_mag < w_fin.b_mag;
  assign w_mag_eq  = w_fin.a_mag == w_fin.b_mag;
  assign w_any_nan = w_fin.a_nan | w_fin.b_nan;

  // Zeros (including flushed denormals) are signless and sit between the two signs.
  always_comb begin
    w_eq = (w_fin.a_zero & w_fin.b_zero) |
           (~w_fin.a_zero & ~w_fin.b_zero & (w_fin.a_sign == w_fin.b_sign) & w_mag_eq);
    w_lt = 1'b0;
    if (w_fin.a_zero && w_fin.b_zero)  w_lt = 1'b0;
    else if (w_fin.a_zero)             w_lt = ~w_fin.b_sign;
    else if (w_fin.b_zero)             w_lt = w_fin.a_sign;
    else if (w_fin.a_sign != w_fin.b_sign) w_lt = w_fin.a_sign;
    else if (w_fin.a_sign)             w_lt = ~w_mag_lt & ~w_mag_eq;
    else                               w_lt = w_mag_lt;
  end

  always_comb begin
    w_res   = 1'b0;
    w_unord = 1'b0;
    case (w_fin.mode)
      MODE_ISPOS: begin
        w_unord = w_fin.a_nan;
        w_res   = ~w_fin.a_nan & ~w_fin.a_zero & ~w_fin.a_sign;
      end
      MODE_ISNEG: begin
        w_unord = w_fin.a_nan;
        w_res   = ~w_fin.a_nan & ~w_fin.a_zero & w_fin.a_sign;
      end
      MODE_ISZERO: begin
        w_unord = w_fin.a_nan;
        w_res   = w_fin.a_zero;
      end
      MODE_EQ: begin
        w_unord = w_any_nan;
        w_res   = ~w_any_nan & w_eq;
      end
      MODE_LT: begin
        w_unord = w_any_nan;
        w_res   = ~w_any_nan & w_lt;
      end
      MODE_LE: begin
        w_unord = w_any_nan;
        w_res   = ~w_any_nan & (w_lt | w_eq);
      end
      MODE_ISNAN: w_res = w_fin.a_nan;
      default:    w_unord = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ready     <= 1'b0;
      r_result    <= 1'b0;
      r_unordered <= 1'b0;
    end else begin
      r_ready <= r_v[LATENCY-1];
      if (r_v[LATENCY-1]) begin
        r_result    <= w_res;
        r_unordered <= w_unord;
      end
    end
  end

  assign o_result    = r_result;
  assign o_unordered = r_unordered;
  assign o_ready     = r_ready;
  assign o_busy      = |r_v;

endmodule

// File: tb/tb_fcmp_pipe.sv
// tb/tb_fcmp_pipe.sv - self-checking bench for fcmp_pipe
// Reference model orders values by a signed integer key derived from the float fields.
module tb_fcmp_pipe;
  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  mode = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        result, unordered, ready, busy;

  int errors = 0;
  int checks = 0;

  bit          s_st [64];
  logic [2:0]  s_md [64];
  logic [31:0] s_a  [64];
  logic [31:0] s_b  [64];
  logic        o_rdy [80];
  logic        o_res [80];
  logic        o_un  [80];
  logic        o_bsy [80];

  bit hold_res = 1'b0;
  bit hold_un  = 1'b0;

  fcmp_pipe #(.EXP_W(8), .MAN_W(23), .LATENCY(L)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_mode(mode),
    .i_op_a(op_a), .i_op_b(op_b),
    .o_result(result), .o_unordered(unordered), .o_ready(ready), .o_busy(busy)
  );

  always #5 clk = ~clk;

  function automatic bit m_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 0);
  endfunction

  function automatic longint m_key(input logic [31:0] x);
    longint mag;
    if (x[30:23] == 8'h00) return 0;
    mag = longint'(x[30:23]) * 64'd8388608 + longint'(x[22:0]);
    return x[31] ? -mag : mag;
  endfunction

  function automatic void m_cmp(input logic [2:0] md, input logic [31:0] x, input logic [31:0] y,
                                output bit r, output bit u);
    bit nx = m_nan(x);
    bit ny = m_nan(y);
    longint kx = m_key(x);
    longint ky = m_key(y);
    r = 0; u = 0;
    case (md)
      3'd0: if (nx) u = 1; else r = (kx > 0);
      3'd1: if (nx) u = 1; else r = (kx < 0);
      3'd2: if (nx) u = 1; else r = (kx == 0);
      3'd3: if (nx || ny) u = 1; else r = (kx == ky);
      3'd4: if (nx || ny) u = 1; else r = (kx < ky);
      3'd5: if (nx || ny) u = 1; else r = (kx <= ky);
      3'd6: r = nx;
      default: u = 1;
    endcase
  endfunction

  function automatic logic [31:0] pick_op();
    logic [31:0] sp [12];
    sp[0] = 32'h00000000; sp[1] = 32'h80000000; sp[2] = 32'h00000001; sp[3]  = 32'h807FFFFF;
    sp[4] = 32'h3F800000; sp[5] = 32'hBF800000; sp[6] = 32'h7F800000; sp[7]  = 32'hFF800000;
    sp[8] = 32'h7FC00000; sp[9] = 32'hFFC00000; sp[10] = 32'h7F800001; sp[11] = 32'h40000000;
    if ($urandom_range(0, 2) == 0) return $urandom;
    return sp[$urandom_range(0, 11)];
  endfunction

  // Drives s_* for n cycles then drains; records outputs sampled 1ns after each edge.
  task automatic drive_stream(input int n);
    for (int i = 0; i < n + L + 1; i++) begin
      if (i < n) begin
        start = s_st[i]; mode = s_md[i]; op_a = s_a[i]; op_b = s_b[i];
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      o_rdy[i] = ready; o_res[i] = result; o_un[i] = unordered; o_bsy[i] = busy;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; mode = 3'd0; op_a = 32'h3F800000;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({ready, result, unordered, busy} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: rdy/res/un/busy=%b required 0000", i, {ready, result, unordered, busy});
      end
    end
    start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({ready, busy} !== 2'b00) begin
        errors++;
        $display("FAIL reset_release cyc%0d: rdy/busy=%b required 00", i, {ready, busy});
      end
    end
  endtask

  task automatic test_ispos_latency();
    logic [3:0] exp_rdy;
    logic [3:0] exp_bsy;
    exp_rdy = 4'b0100;
    exp_bsy = 4'b0011;
    start = 1'b1; mode = 3'd0; op_a = 32'h3F800000; op_b = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (ready !== exp_rdy[i] || busy !== exp_bsy[i]) begin
        errors++;
        $display("FAIL ispos_timing edge%0d: rdy=%b busy=%b required rdy=%b busy=%b",
                 i, ready, busy, exp_rdy[i], exp_bsy[i]);
      end
      if (i >= 2) begin
        checks++;
        if (result !== 1'b1 || unordered !== 1'b0) begin
          errors++;
          $display("FAIL ispos_value edge%0d: res=%b un=%b required res=1 un=0", i, result, unordered);
        end
      end
    end
    hold_res = 1; hold_un = 0;
  endtask

  task automatic test_back_to_back();
    bit er [10];
    bit eu [10];
    int n = 10;
    s_md[0] = 3'd0; s_a[0] = 32'h3F800000; s_b[0] = 32'h0;        er[0] = 1; eu[0] = 0;
    s_md[1] = 3'd3; s_a[1] = 32'h80000000; s_b[1] = 32'h00000000; er[1] = 1; eu[1] = 0;
    s_md[2] = 3'd3; s_a[2] = 32'h00000001; s_b[2] = 32'h00000000; er[2] = 1; eu[2] = 0;
    s_md[3] = 3'd4; s_a[3] = 32'hBF800000; s_b[3] = 32'h3F800000; er[3] = 1; eu[3] = 0;
    s_md[4] = 3'd4; s_a[4] = 32'hC0000000; s_b[4] = 32'hBF800000; er[4] = 1; eu[4] = 0;
    s_md[5] = 3'd5; s_a[5] = 32'h7F800000; s_b[5] = 32'h7F800000; er[5] = 1; eu[5] = 0;
    s_md[6] = 3'd4; s_a[6] = 32'h7FC00000; s_b[6] = 32'h3F800000; er[6] = 0; eu[6] = 1;
    s_md[7] = 3'd1; s_a[7] = 32'hFFC00000; s_b[7] = 32'h0;        er[7] = 0; eu[7] = 1;
    s_md[8] = 3'd6; s_a[8] = 32'hFFC00000; s_b[8] = 32'h0;        er[8] = 1; eu[8] = 0;
    s_md[9] = 3'd7; s_a[9] = 32'h3F800000; s_b[9] = 32'h3F800000; er[9] = 0; eu[9] = 1;
    for (int i = 0; i < n; i++) s_st[i] = 1'b1;
    drive_stream(n);
    for (int i = 0; i < n + L + 1; i++) begin
      bit ey = (i >= L) && (i - L < n);
      checks++;
      if (o_rdy[i] !== ey) begin
        errors++;
        $display("FAIL b2b_ready sample%0d: got %b required %b", i, o_rdy[i], ey);
      end
      if (ey) begin
        checks++;
        if (o_res[i] !== er[i-L] || o_un[i] !== eu[i-L]) begin
          errors++;
          $display("FAIL b2b_value op%0d: res=%b un=%b required res=%b un=%b",
                   i - L, o_res[i], o_un[i], er[i-L], eu[i-L]);
        end
      end
    end
    hold_res = 0; hold_un = 1;
  endtask

  task automatic test_bubbles();
    int n = 8;
    int pulses = 0;
    for (int i = 0; i < n; i++) begin
      s_st[i] = (i % 2 == 0);
      s_md[i] = 3'($urandom_range(0, 6));
      s_a[i] = pick_op();
      s_b[i] = ($urandom_range(0, 2) == 0) ? s_a[i] : pick_op();
    end
    s_md[0] = 3'd0; s_a[0] = 32'h3F800000;
    drive_stream(n);
    for (int i = 0; i < n + L + 1; i++) begin
      bit ey = (i >= L) && (i - L < n) && s_st[i-L];
      if (ey) m_cmp(s_md[i-L], s_a[i-L], s_b[i-L], hold_res, hold_un);
      if (o_rdy[i] === 1'b1) pulses++;
      checks++;
      if (o_rdy[i] !== ey) begin
        errors++;
        $display("FAIL bubble_ready sample%0d: got %b required %b", i, o_rdy[i], ey);
      end
      checks++;
      if (o_res[i] !== hold_res || o_un[i] !== hold_un) begin
        errors++;
        $display("FAIL bubble_value sample%0d: res=%b un=%b required res=%b un=%b",
                 i, o_res[i], o_un[i], hold_res, hold_un);
      end
    end
    checks++;
    if (pulses != 4) begin
      errors++;
      $display("FAIL bubble_pulses: got %0d required 4", pulses);
    end
  endtask

  task automatic test_random();
    int n = 48;
    for (int i = 0; i < n; i++) begin
      s_st[i] = ($urandom_range(0, 3) != 0);
      s_md[i] = 3'($urandom_range(0, 7));
      s_a[i] = pick_op();
      case ($urandom_range(0, 3))
        0: s_b[i] = s_a[i];
        1: s_b[i] = s_a[i] ^ 32'h80000000;
        default: s_b[i] = pick_op();
      endcase
    end
    drive_stream(n);
    for (int i = 0; i < n + L + 1; i++) begin
      bit ey = (i >= L) && (i - L < n) && s_st[i-L];
      bit eb = 0;
      for (int k = i - L + 1; k <= i; k++)
        if (k >= 0 && k < n && s_st[k]) eb = 1;
      if (ey) m_cmp(s_md[i-L], s_a[i-L], s_b[i-L], hold_res, hold_un);
      checks++;
      if (o_rdy[i] !== ey || o_bsy[i] !== eb) begin
        errors++;
        $display("FAIL rand_ctrl sample%0d: rdy=%b busy=%b required rdy=%b busy=%b",
                 i, o_rdy[i], o_bsy[i], ey, eb);
      end
      checks++;
      if (o_res[i] !== hold_res || o_un[i] !== hold_un) begin
        errors++;
        $display("FAIL rand_value sample%0d: res=%b un=%b required res=%b un=%b (a=%h b=%h)",
                 i, o_res[i], o_un[i], hold_res, hold_un,
                 (i >= L && i - L < n) ? s_a[i-L] : 32'h0, (i >= L && i - L < n) ? s_b[i-L] : 32'h0);
      end
    end
  endtask

  task automatic test_reset_inflight();
    start = 1'b1; mode = 3'd0; op_a = 32'h3F800000;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (ready !== 1'b1 || result !== 1'b1) begin
      errors++;
      $display("FAIL inflight_pre: rdy=%b res=%b required rdy=1 res=1", ready, result);
    end
    start = 1'b1; mode = 3'd7;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL inflight_busy: got %b required 1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ready, result, unordered, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL inflight_async: rdy/res/un/busy=%b required 0000", {ready, result, unordered, busy});
    end
    @(posedge clk); #1;
    checks++;
    if ({ready, busy} !== 2'b00) begin
      errors++;
      $display("FAIL inflight_edge2: rdy/busy=%b required 00", {ready, busy});
    end
    rst_n = 1'b1;
    hold_res = 0; hold_un = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({ready, result, unordered, busy} !== 4'b0000) begin
        errors++;
        $display("FAIL inflight_after cyc%0d: rdy/res/un/busy=%b required 0000", i, {ready, result, unordered, busy});
      end
    end
  endtask

  initial begin
    test_reset();
    test_ispos_latency();
    test_back_to_back();
    test_bubbles();
    test_random();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fcmp_pipe.md
FCMP_PIPE -- requirements
Module: fcmp_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent width.
REQ-002 SHALL have parameter MAN_W, default 23, mantissa width; operand width W = 1+EXP_W+MAN_W.
REQ-003 SHALL have parameter LATENCY, default 2, legal 1..4, start-to-ready cycles.
REQ-004 clk  in  1  rising-edge clock; single clock domain.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  operation valid; sampled every rising edge.
REQ-007 mode  in  3  operation select, captured with start.
REQ-008 op_a  in  W  first operand, sign bit at MSB.
REQ-009 op_b  in  W  second operand; ignored by unary modes.
REQ-010 result  out  1  boolean outcome of the retiring operation.
REQ-011 unordered  out  1  retiring operation involved a NaN, or mode was reserved.
REQ-012 ready  out  1  one-cycle pulse per retiring operation.
REQ-013 busy  out  1  high while any pipeline stage holds a valid operation.

Function
REQ-014 Classification SHALL be: zero = exponent all-0 (denormals flushed to zero, sign ignored); NaN = exponent all-1 and mantissa non-zero; infinity = exponent all-1 and mantissa 0, ordered normally.
REQ-015 Modes SHALL be: 000 ISPOS (a>0), 001 ISNEG (a<0), 010 ISZERO, 011 EQ (a==b), 100 LT (a<b), 101 LE (a<=b), 110 ISNAN (a is NaN), 111 reserved.
REQ-016 ISPOS and ISNEG SHALL return 0 for any zero or NaN operand.
REQ-017 +0 and -0 SHALL compare equal; flushed denormals SHALL compare equal to zero.
REQ-018 LT/LE ordering SHALL be sign-magnitude: negative below positive; magnitudes compared on {exponent, mantissa}; order reversed when both are negative.
REQ-019 EQ, LT and LE with either operand NaN SHALL give result=0 and unordered=1.
REQ-020 ISPOS, ISNEG and ISZERO with a NaN op_a SHALL give result=0 and unordered=1; ISNAN SHALL never set unordered.
REQ-021 Reserved mode 111 SHALL give result=0 and unordered=1.
REQ-022 Operands, mode and valid SHALL be registered on every edge with start=1, with no stall and no backpressure.
REQ-023 Throughput SHALL be one operation per cycle; back-to-back starts SHALL each retire exactly LATENCY cycles after capture, in order.
REQ-024 ready SHALL assert on the edge exactly LATENCY cycles after the capturing edge, for one cycle, with result and unordered valid in that same cycle.
REQ-025 result and unordered SHALL hold their last retired values until the next retirement; they SHALL not change while ready=0.
REQ-026 With LATENCY=1, ready SHALL assert in the cycle after capture; for LATENCY>1, classification SHALL be in stage 1, decision in the final stage, and validity carried through shift stages between them.
REQ-027 busy SHALL equal the OR of all stage-valid bits; it SHALL be 0 in the cycle after the last retirement when no start is pending.
REQ-028 start=0 cycles SHALL insert bubbles; bubbles SHALL produce no ready pulse.

Reset
REQ-029 reset=0 SHALL immediately and asynchronously clear result, unordered, ready, busy and all stage-valid bits to 0.
REQ-030 Operations in flight at reset assertion SHALL be discarded, with no ready pulse after reset release.
REQ-031 start SHALL not be captured on any edge while reset=0; the first edge with reset=1 SHALL capture normally.

Verification (default params, LATENCY=2)
REQ-032 ISPOS, a=0x3F800000, start at edge 0 -> ready=1, result=1, unordered=0 at edge 2; ready=0 at edge 3.
REQ-033 EQ, a=0x80000000, b=0x00000000 -> result=1; EQ, a=0x00000001, b=0x00000000 -> result=1 (denormal flush).
REQ-034 Four back-to-back starts: LT(0xBF800000,0x3F800000)=1, LT(0xC0000000,0xBF800000)=1, LE(0x7F800000,0x7F800000)=1, LT(0x7FC00000,0x3F800000) -> result 1,1,1,0 with unordered 0,0,0,1 on four consecutive ready cycles.
REQ-035 ISNEG on 0xFFC00000 -> result=0, unordered=1; ISNAN on the same value -> result=1, unordered=0; mode 111 -> result=0, unordered=1.
REQ-036 start at edge 0, reset pulsed low between edges 1 and 2 -> outputs 0 immediately, no ready at edge 2, busy=0.
REQ-037 Alternating start/bubble for 8 cycles -> exactly 4 ready pulses, each 2 cycles after its start, with result held between pulses.
